scrypt_nonce_ctrl: RTL and testbench

SCRYPT_NONCE_CTRL -- requirements
Module: scrypt_nonce_ctrl

---
 rtl/scrypt_nonce_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_scrypt_nonce_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrypt_nonce_ctrl.sv
// Nonce sweep controller for an external scrypt core: launches one hash per nonce, reports the first hash <= target.
// Define SCRYPT_NONCE_TIMEOUT_EN to add a per-hash watchdog that aborts the job and raises job_error.
module scrypt_nonce_ctrl #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd4000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [639:0] job_header,
    input  logic [255:0] job_target,
    input  logic [31:0]  job_nonce_end,
    input  logic         abort,
    output logic         core_init,
    output logic [639:0] core_in,
    input  logic [255:0] core_out,
    input  logic         core_valid,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         job_done,
    output logic         job_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_REPORT,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [607:0]   header_q, header_d;
    logic [255:0]   target_q, target_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [255:0]   hash_q, hash_d;
    logic           job_ready_q, job_ready_d;
    logic           core_init_q, core_init_d;
    logic [639:0]   core_in_q, core_in_d;
    logic           found_valid_q, found_valid_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [255:0]   found_hash_q, found_hash_d;
    logic           job_done_q, job_done_d;
    logic           end_job;

`ifdef SCRYPT_NONCE_TIMEOUT_EN
    logic [31:0]    wdog_q, wdog_d;
    logic           job_error_q, job_error_d;
    logic           timeout;

    assign timeout   = (wdog_q == (TIMEOUT_CYCLES - 32'd1));
    assign job_error = job_error_q;

    // Counts consecutive WAIT/DRAIN cycles; any other state clears it.
    always_comb begin
        wdog_d = '0;
        if (state_q == S_WAIT || state_q == S_DRAIN) begin
            wdog_d = wdog_q + 32'd1;
        end
    end
`else
    // Watchdog compiled out; the limit is only referenced to keep the parameter in the interface.
    assign job_error = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        target_d      = target_q;
        nonce_end_d   = nonce_end_q;
        nonce_d       = nonce_q;
        hash_d        = hash_q;
        job_ready_d   = job_ready_q;
        core_init_d   = 1'b0;
        core_in_d     = core_in_q;
        found_valid_d = found_valid_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        job_done_d    = 1'b0;
        end_job       = 1'b0;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
        job_error_d   = job_error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (job_valid && job_ready_q) begin
                    header_d    = job_header[639:32];
                    target_d    = job_target;
                    nonce_end_d = job_nonce_end;
                    nonce_d     = job_header[31:0];
                    core_in_d   = job_header;
                    core_init_d = 1'b1;
                    job_ready_d = 1'b0;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
                    job_error_d = 1'b0;
`endif
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (abort) begin
                    end_job = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    // A result arriving with the abort is simply discarded.
                    if (core_valid) begin
                        end_job = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (core_valid) begin
                    hash_d  = core_out;
                    state_d = S_CHECK;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
                end else if (timeout) begin
                    job_error_d = 1'b1;
                    end_job     = 1'b1;
`endif
                end
            end
            S_CHECK: begin
                if (abort) begin
                    end_job = 1'b1;
                end else if (hash_q <= target_q) begin
                    found_valid_d = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = hash_q;
                    state_d       = S_REPORT;
                end else if (nonce_q >= nonce_end_q) begin
                    // >= also ends a range whose end lies below the start, and 32'hFFFFFFFF never increments.
                    end_job = 1'b1;
                end else begin
                    nonce_d     = nonce_q + 32'd1;
                    core_in_d   = {header_q, nonce_q + 32'd1};
                    core_init_d = 1'b1;
                    state_d     = S_LAUNCH;
                end
            end
            S_REPORT: begin
                if (abort || found_ready) begin
                    end_job = 1'b1;
                end
            end
            S_DRAIN: begin
                if (core_valid) begin
                    end_job = 1'b1;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
                end else if (timeout) begin
                    job_error_d = 1'b1;
                    end_job     = 1'b1;
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                job_ready_d = 1'b1;
            end
        endcase

        if (end_job) begin
            state_d       = S_IDLE;
            job_ready_d   = 1'b1;
            job_done_d    = 1'b1;
            found_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            header_q      <= '0;
            target_q      <= '0;
            nonce_end_q   <= '0;
            nonce_q       <= '0;
            hash_q        <= '0;
            job_ready_q   <= 1'b1;
            core_init_q   <= 1'b0;
            core_in_q     <= '0;
            found_valid_q <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            job_done_q    <= 1'b0;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
            wdog_q        <= '0;
            job_error_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            target_q      <= target_d;
            nonce_end_q   <= nonce_end_d;
            nonce_q       <= nonce_d;
            hash_q        <= hash_d;
            job_ready_q   <= job_ready_d;
            core_init_q   <= core_init_d;
            core_in_q     <= core_in_d;
            found_valid_q <= found_valid_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            job_done_q    <= job_done_d;
`ifdef SCRYPT_NONCE_TIMEOUT_EN
            wdog_q        <= wdog_d;
            job_error_q   <= job_error_d;
`endif
        end
    end

    assign job_ready   = job_ready_q;
    assign core_init   = core_init_q;
    assign core_in     = core_in_q;
    assign found_valid = found_valid_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign job_done    = job_done_q;

endmodule

// File: tb/tb_scrypt_nonce_ctrl.sv
// Directed bench for scrypt_nonce_ctrl with a simple fixed-latency core stand-in.
module tb_scrypt_nonce_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         job_valid;
    logic         job_ready;
    logic [639:0] job_header;
    logic [255:0] job_target;
    logic [31:0]  job_nonce_end;
    logic         abort;
    logic         core_init;
    logic [639:0] core_in;
    logic [255:0] core_out;
    logic         core_valid;
    logic         found_valid;
    logic         found_ready;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         job_done;
    logic         job_error;

    int n_cmp = 0;
    int n_bad = 0;

    // core stand-in / monitor state (written only by the model process)
    int           cyc = 0;
    int           init_cnt = 0;
    int           done_cnt = 0;
    int           fv_cnt = 0;
    int           pend = 0;
    logic [31:0]  nonce_log [0:63];
    // core stand-in controls (written only by the main process)
    int           core_lat = 3;
    bit           core_auto = 1'b1;
    int           fire_cyc = -1;
    logic [255:0] core_hash = 256'h0;

    localparam logic [255:0] ONES = {256{1'b1}};
    localparam logic [607:0] HDR_HI = {32'hDEADBEEF, 544'h0, 32'hCAFEF00D};

    scrypt_nonce_ctrl #(.TIMEOUT_CYCLES(32'd100)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_header(job_header), .job_target(job_target), .job_nonce_end(job_nonce_end),
        .abort(abort),
        .core_init(core_init), .core_in(core_in), .core_out(core_out), .core_valid(core_valid),
        .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash),
        .job_done(job_done), .job_error(job_error)
    );

    always #5 clk = ~clk;

    initial begin
        core_valid = 1'b0;
        core_out   = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            core_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_valid = 1'b1;
                    core_out   = core_hash;
                end
            end
            if (cyc == fire_cyc) begin
                core_valid = 1'b1;
                core_out   = core_hash;
            end
            if (core_init === 1'b1) begin
                if (init_cnt < 64) nonce_log[init_cnt] = core_in[31:0];
                init_cnt++;
                if (core_auto) pend = core_lat;
            end
            if (job_done === 1'b1) done_cnt++;
            if (found_valid === 1'b1) fv_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, required finish before time limit");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [639:0] hdr, input logic [255:0] tgt, input logic [31:0] nend);
        @(negedge clk);
        chk("job_ready_before_job", job_ready, 1'b1);
        job_header    = hdr;
        job_target    = tgt;
        job_nonce_end = nend;
        job_valid     = 1'b1;
        @(negedge clk);
        job_valid     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited);
        int d0;
        d0 = done_cnt;
        waited = 0;
        while (done_cnt == d0 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        chk("job_done_within_budget", (done_cnt != d0), 1'b1);
    endtask

    task automatic wait_found(input int budget);
        int w;
        w = 0;
        while (found_valid !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk("found_valid_within_budget", found_valid, 1'b1);
    endtask

    initial begin
        int w;
        int base;
        int f0;
        int d0;
        logic [639:0] hdr;

        reset_n       = 1'b0;
        job_valid     = 1'b0;
        job_header    = '0;
        job_target    = '0;
        job_nonce_end = '0;
        abort         = 1'b0;
        found_ready   = 1'b1;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_job_ready", job_ready, 1'b1);
        chk("rst_core_init", core_init, 1'b0);
        chk("rst_core_in", core_in, 640'h0);
        chk("rst_found_valid", found_valid, 1'b0);
        chk("rst_found_nonce", found_nonce, 32'h0);
        chk("rst_found_hash", found_hash, 256'h0);
        chk("rst_job_done", job_done, 1'b0);
        chk("rst_job_error", job_error, 1'b0);
        reset_n = 1'b1;

        // first-try hit with all-ones target
        core_hash = 256'h1234;
        hdr = {HDR_HI, 32'h0E0904A0};
        start_job(hdr, ONES, 32'h0E0904A0);
        chk("A_core_init", core_init, 1'b1);
        chk("A_core_in", core_in, hdr);
        @(negedge clk);
        chk("A_core_init_one_cycle", core_init, 1'b0);
        chk("A_core_in_stable", core_in, hdr);
        wait_found(50);
        chk("A_found_nonce", found_nonce, 32'h0E0904A0);
        chk("A_found_hash", found_hash, 256'h1234);
        @(negedge clk);
        chk("A_job_done", job_done, 1'b1);
        chk("A_found_dropped", found_valid, 1'b0);
        chk("A_job_ready", job_ready, 1'b1);
        chk("A_job_error", job_error, 1'b0);
        @(negedge clk);
        chk("A_job_done_pulse", job_done, 1'b0);

        // four-nonce sweep, nothing found
        core_hash = 256'h5;
        base = init_cnt;
        f0 = fv_cnt;
        start_job({HDR_HI, 32'h00000010}, 256'h0, 32'h00000013);
        wait_done(200, w);
        chk("B_init_count", init_cnt - base, 4);
        for (int i = 0; i < 4; i++) chk("B_nonce_seq", nonce_log[base + i], 32'h10 + i);
        chk("B_no_found", fv_cnt - f0, 0);
        chk("B_job_ready", job_ready, 1'b1);

        // end below start: single nonce, no wrap
        base = init_cnt;
        start_job({HDR_HI, 32'hFFFFFFFE}, 256'h0, 32'h00000005);
        wait_done(100, w);
        chk("C_init_count", init_cnt - base, 1);
        chk("C_nonce", nonce_log[base], 32'hFFFFFFFE);

        // top of the nonce space: stop at FFFFFFFF
        base = init_cnt;
        start_job({HDR_HI, 32'hFFFFFFFF}, 256'h0, 32'hFFFFFFFF);
        wait_done(100, w);
        chk("C2_init_count", init_cnt - base, 1);

        // hash exactly equal to target is a hit
        core_hash = 256'h77;
        start_job({HDR_HI, 32'h00000100}, 256'h77, 32'h00000105);
        wait_found(50);
        chk("F_eq_target_nonce", found_nonce, 32'h00000100);

        @(negedge clk);
        // held result with consumer stalled for 10 cycles
        found_ready = 1'b0;
        core_hash = 256'h99;
        start_job({HDR_HI, 32'hA5A50001}, ONES, 32'hA5A50009);
        wait_found(50);
        for (int i = 0; i < 10; i++) begin
            chk("E_found_valid_hold", found_valid, 1'b1);
            chk("E_found_nonce_hold", found_nonce, 32'hA5A50001);
            chk("E_no_done_while_held", job_done, 1'b0);
            @(negedge clk);
        end
        found_ready = 1'b1;
        @(negedge clk);
        chk("E_job_done", job_done, 1'b1);
        chk("E_found_dropped", found_valid, 1'b0);

        // abort while a result is presented
        found_ready = 1'b0;
        start_job({HDR_HI, 32'h00000200}, ONES, 32'h00000200);
        wait_found(50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("I_found_dropped", found_valid, 1'b0);
        chk("I_job_done", job_done, 1'b1);
        chk("I_job_ready", job_ready, 1'b1);
        found_ready = 1'b1;

        // abort in WAIT, core answers 50 cycles later
        core_auto = 1'b0;
        f0 = fv_cnt;
        start_job({HDR_HI, 32'h00000300}, ONES, 32'h00000310);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("G_no_early_done", job_done, 1'b0);
        chk("G_busy_in_drain", job_ready, 1'b0);
        fire_cyc = cyc + 50;
        wait_done(100, w);
        chk("G_done_after_core", cyc, fire_cyc + 1);
        chk("G_job_ready", job_ready, 1'b1);
        chk("G_no_found", fv_cnt - f0, 0);
        fire_cyc = -1;
        core_auto = 1'b1;

        // abort coincides with core_valid in WAIT
        f0 = fv_cnt;
        start_job({HDR_HI, 32'h00000400}, ONES, 32'h00000410);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("H_job_done", job_done, 1'b1);
        chk("H_job_ready", job_ready, 1'b1);
        @(negedge clk);
        chk("H_job_done_pulse", job_done, 1'b0);
        chk("H_result_discarded", fv_cnt - f0, 0);

`ifdef SCRYPT_NONCE_TIMEOUT_EN
        // watchdog: core never answers
        core_auto = 1'b0;
        start_job({HDR_HI, 32'h00000500}, ONES, 32'h00000500);
        wait_done(300, w);
        chk("T_timeout_cycle", w, 101);
        chk("T_job_error", job_error, 1'b1);
        @(negedge clk);
        chk("T_job_error_sticky", job_error, 1'b1);
        core_auto = 1'b1;
        start_job({HDR_HI, 32'h00000600}, 256'h0, 32'h00000600);
        chk("T_job_error_cleared", job_error, 1'b0);
        wait_done(50, w);
`endif

        // reset mid-WAIT, core answers afterwards
        f0 = fv_cnt;
        d0 = done_cnt;
        start_job({HDR_HI, 32'h00000700}, ONES, 32'h00000700);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("J_rst_job_ready", job_ready, 1'b1);
        chk("J_rst_core_in", core_in, 640'h0);
        chk("J_rst_core_init", core_init, 1'b0);
        chk("J_rst_job_error", job_error, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        base = init_cnt;
        repeat (8) @(negedge clk);
        chk("J_no_found", fv_cnt - f0, 0);
        chk("J_no_done", done_cnt - d0, 0);
        chk("J_no_relaunch", init_cnt - base, 0);
        chk("J_idle_ready", job_ready, 1'b1);
        chk("J_found_nonce_rst", found_nonce, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
